// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA key-generation datapath.
// Holds the default operand width, the lcm_32 FSM states and the counter-width helper.
package rsa_pkg;

    localparam int unsigned DefaultW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StMul,
        StDone
    } lcm_state_e;

    // Wide enough to count to W inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned DefaultCntW = cnt_width(DefaultW);

endpackage

// File: rtl/divu_seq.sv
// W-cycle unsigned restoring divider, one quotient bit per cycle, MSB first.
// The first step is taken from the raw inputs on the start edge; done pulses after the last step.
module divu_seq import rsa_pkg::*; #(
    parameter int unsigned W = DefaultW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int unsigned CntW = cnt_width(W);

    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;
    logic            done_q, done_d;

    logic [W-1:0]    step_quo;
    logic [W-1:0]    step_rem;
    logic [W-1:0]    step_dvs;
    logic [W:0]      shifted;
    logic [W:0]      trial;

    always_comb begin
        step_quo = run_q ? quo_q : dividend;
        step_rem = run_q ? rem_q : '0;
        step_dvs = run_q ? dvs_q : divisor;
        shifted  = {step_rem, step_quo[W-1]};
        trial    = shifted - {1'b0, step_dvs};

        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;

        if (run_q || start) begin
            // A clear top bit means the trial subtraction did not borrow.
            if (!trial[W]) begin
                rem_d = trial[W-1:0];
                quo_d = {step_quo[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {step_quo[W-2:0], 1'b0};
            end
            dvs_d = step_dvs;
            if (run_q) begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(W - 1)) begin
                    run_d  = 1'b0;
                    done_d = 1'b1;
                end
            end else begin
                cnt_d = CntW'(1);
                run_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/lcm_32.sv
// Sequential lcm = (ina / g) * inb using a W-cycle restoring divider then a W-cycle shift-add
// multiplier; zero operands and a non-dividing gcd short-circuit to result 0.
module lcm_32 import rsa_pkg::*; #(
    parameter int unsigned W = DefaultW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   ina,
    input  logic [W-1:0]   inb,
    input  logic [W-1:0]   g,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           err
);

    localparam int unsigned CntW = cnt_width(W);

    lcm_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    inb_q, inb_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic            flag_q, flag_d;
    logic [2*W-1:0]  result_q, result_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            div_start;
    logic            div_done;
    logic [W-1:0]    div_quo;
    logic [W-1:0]    div_rem;
    logic            any_zero;

    divu_seq #(
        .W (W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (ina),
        .divisor   (g),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inb_d     = inb_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        flag_d    = flag_q;
        result_d  = result_q;
        err_d     = err_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        div_start = 1'b0;
        any_zero  = (ina == '0) || (inb == '0) || (g == '0);

        unique case (state_q)
            StIdle: begin
                // The done-pulse cycle still counts as part of DONE, so start is ignored there.
                if (start && !done_q) begin
                    inb_d  = inb;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    if (any_zero) begin
                        acc_d   = '0;
                        flag_d  = (g == '0) && ((ina | inb) != '0);
                        state_d = StDone;
                    end else begin
                        div_start = 1'b1;
                        flag_d    = 1'b0;
                        state_d   = StDiv;
                    end
                end
            end
            StDiv: begin
                if (div_done) begin
                    acc_d = '0;
                    if (div_rem != '0) begin
                        flag_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        mcand_d  = {{W{1'b0}}, inb_q};
                        mplier_d = div_quo;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end
                end
            end
            StMul: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                result_d = acc_q;
                err_d    = flag_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            inb_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            flag_q   <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inb_q    <= inb_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            flag_q   <= flag_d;
            result_q <= result_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_lcm_32.sv
// Directed bench for lcm_32: a vector table checked for result, err, latency and busy length,
// plus hand-written sequences for ignored starts and a mid-operation reset.
module tb_lcm_32;

    localparam int W       = 32;
    localparam int LatNorm = 2 * W + 1;
    localparam int LatZero = 1;
    localparam int LatErr  = W + 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   ina;
    logic [W-1:0]   inb;
    logic [W-1:0]   g;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           err;

    int compared;
    int mismatched;
    int done_cnt;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   gg;
        logic [2*W-1:0] res;
        logic           e;
        int             lat;
    } vec_t;

    vec_t vecs[12];

    lcm_32 #(
        .W (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ina    (ina),
        .inb    (inb),
        .g      (g),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Launches one operation and waits (bounded) for its done pulse.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] gg,
                          output int lat, output logic [63:0] res, output logic e,
                          output int busy_cycles);
        @(negedge clk);
        start = 1'b1;
        ina   = a;
        inb   = b;
        g     = gg;
        @(posedge clk);
        #1;
        start = 1'b0;
        ina   = $urandom;
        inb   = $urandom;
        g     = $urandom;
        lat         = -1;
        res         = '0;
        e           = 1'b0;
        busy_cycles = 0;
        for (int k = 1; k <= 200; k++) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                res = result;
                e   = err;
                break;
            end
        end
    endtask

    initial begin
        int             lat;
        int             bc;
        int             dc;
        logic [63:0]    res;
        logic           e;
        string          tag;

        compared   = 0;
        mismatched = 0;
        done_cnt   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        ina        = '0;
        inb        = '0;
        g          = '0;

        vecs[0]  = '{32'd10, 32'd20, 32'd10, 64'd20, 1'b0, LatNorm};
        vecs[1]  = '{32'd640, 32'd120, 32'd40, 64'd1920, 1'b0, LatNorm};
        vecs[2]  = '{32'd9919398, 32'd1993112, 32'd2, 64'd9885235593288, 1'b0, LatNorm};
        vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 64'hFFFFFFFD_00000002, 1'b0, LatNorm};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_FFFFFFFF, 1'b0, LatNorm};
        vecs[5]  = '{32'd12, 32'd18, 32'd6, 64'd36, 1'b0, LatNorm};
        vecs[6]  = '{32'h80000000, 32'd3, 32'd1, 64'h1_80000000, 1'b0, LatNorm};
        vecs[7]  = '{32'd0, 32'd5, 32'd5, 64'd0, 1'b0, LatZero};
        vecs[8]  = '{32'd7, 32'd9, 32'd0, 64'd0, 1'b1, LatZero};
        vecs[9]  = '{32'd0, 32'd0, 32'd0, 64'd0, 1'b0, LatZero};
        vecs[10] = '{32'd10, 32'd20, 32'd3, 64'd0, 1'b1, LatErr};
        vecs[11] = '{32'd10, 32'd0, 32'd10, 64'd0, 1'b0, LatZero};

        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", result, 64'd0);
        check("reset err", 64'(err), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].gg, lat, res, e, bc);
            tag = $sformatf("vec%0d", i);
            check({tag, " latency"}, 64'(lat), 64'(vecs[i].lat));
            check({tag, " result"}, res, vecs[i].res);
            check({tag, " err"}, 64'(e), 64'(vecs[i].e));
            check({tag, " busy cycles"}, 64'(bc), 64'(vecs[i].lat));
            repeat (3) @(posedge clk);
            #1;
            check({tag, " result held"}, result, vecs[i].res);
            check({tag, " done dropped"}, 64'(done), 64'd0);
        end

        // Starts during DIV, in the DONE state and in the done-pulse cycle must all be ignored.
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1;
        ina   = 32'd10;
        inb   = 32'd20;
        g     = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        res   = '0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == 10 || k == LatNorm || k == LatNorm + 1) begin
                start = 1'b1;
                ina   = 32'd3;
                inb   = 32'd5;
                g     = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1 && lat < 0) begin
                lat = k;
                res = result;
            end
        end
        start = 1'b0;
        check("ignored-start latency", 64'(lat), 64'(LatNorm));
        check("ignored-start result", res, 64'd20);
        check("ignored-start done count", 64'(done_cnt - dc), 64'd1);
        check("ignored-start final busy", 64'(busy), 64'd0);
        check("ignored-start final result", result, 64'd20);

        // Reset partway through an operation clears outputs at once and yields no done.
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1;
        ina   = 32'd640;
        inb   = 32'd120;
        g     = 32'd40;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        check("async reset result", result, 64'd0);
        check("async reset err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("aborted op done count", 64'(done_cnt - dc), 64'd0);
        check("aborted op result", result, 64'd0);

        run_op(32'd640, 32'd120, 32'd40, lat, res, e, bc);
        check("post-reset latency", 64'(lat), 64'(LatNorm));
        check("post-reset result", res, 64'd1920);
        check("post-reset err", 64'(e), 64'd0);
        check("post-reset busy cycles", 64'(bc), 64'(LatNorm));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
